// File: rtl/wb_core_master_if.sv
// Wishbone B4 pipelined bus bundle shared by masters and slaves.
// clk_i/rst_ni travel with the bundle for slaves that want them; the master ignores them.
interface wishbone_if (
  input logic clk_i,
  input logic rst_ni
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_m;
  logic [31:0] data_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, addr, data_m,
    input  data_s, ack, err, stall
  );

  modport slave (
    input  clk_i, rst_ni, cyc, stb, we, sel, addr, data_m,
    output data_s, ack, err, stall
  );
endinterface

// File: rtl/wb_core_master.sv
// Bridges an Ibex-style req/gnt/rvalid port onto Wishbone B4 pipelined cycles.
// Grant is combinational; responses are registered one cycle after ack/err; err/timeout abort the bus.
module wb_core_master #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  wishbone_if.master  wb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic busy, resp_acc, err_acc, timeout_hit, stb, gnt, retire;

  always_comb begin
    busy        = (state_q == BUSY);
    resp_acc    = busy && (cnt_q != '0) && (wb.ack || wb.err);
    err_acc     = resp_acc && wb.err;
    timeout_hit = (TIMEOUT != 0) && busy && (cnt_q != '0) && (timer_q == T_LAST) && !resp_acc;
    // A timeout retires the oldest transfer as an error, just like a slave err.
    retire      = resp_acc || timeout_hit;
    stb         = !rst_i && core_req_i && (cnt_q < CW'(MAX_OUTSTANDING)) &&
                  (state_q != ABORT) && !wb.err && !timeout_hit;
    gnt         = stb && !wb.stall;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = '0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    if (state_q == ABORT) begin
      if (cnt_q != '0) begin
        cnt_d    = cnt_q - CW'(1);
        rvalid_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      rvalid_d = retire;
      err_d    = err_acc || timeout_hit;
      rdata_d  = (resp_acc && !wb.err) ? wb.data_s : '0;
      if (gnt && !retire) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!gnt && retire) begin
        cnt_d = cnt_q - CW'(1);
      end
      if ((cnt_q != '0) && !resp_acc && (TIMEOUT != 0)) begin
        timer_d = timer_q + TW'(1);
      end
      if (err_acc || timeout_hit) begin
        state_d = ABORT;
      end else if (cnt_d != '0) begin
        state_d = BUSY;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign core_gnt_o    = gnt;
  assign wb.stb        = stb;
  assign wb.cyc        = !rst_i && (stb || ((cnt_q != '0) && (state_q != ABORT)));
  assign wb.we         = core_we_i;
  assign wb.sel        = core_be_i;
  assign wb.addr       = core_addr_i;
  assign wb.data_m     = core_wdata_i;
  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;
endmodule
